// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared light encodings, phase codes, monitor state type and
//               default dwell for the traffic light controller and monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic [1:0] PH_RED    = 2'b00;
    localparam logic [1:0] PH_GREEN  = 2'b01;
    localparam logic [1:0] PH_YELLOW = 2'b10;
    localparam logic [1:0] PH_NONE   = 2'b11;

    localparam int unsigned DEFAULT_DWELL = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRK_R = 2'd1,
        ST_TRK_G = 2'd2,
        ST_TRK_Y = 2'd3
    } mon_state_e;

    // Tracking state matching a legal phase code.
    function automatic mon_state_e phase_to_state(input logic [1:0] ph);
        case (ph)
            PH_RED:    phase_to_state = ST_TRK_R;
            PH_GREEN:  phase_to_state = ST_TRK_G;
            PH_YELLOW: phase_to_state = ST_TRK_Y;
            default:   phase_to_state = ST_IDLE;
        endcase
    endfunction

    // Phase code currently tracked by a state (PH_NONE when idle).
    function automatic logic [1:0] state_to_phase(input mon_state_e st);
        case (st)
            ST_TRK_R: state_to_phase = PH_RED;
            ST_TRK_G: state_to_phase = PH_GREEN;
            ST_TRK_Y: state_to_phase = PH_YELLOW;
            default:  state_to_phase = PH_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_decoder.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_decoder
// Description : Combinational one-hot light bus to {valid, phase} decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_decoder
    import traffic_pkg::*;
(
    input  logic [2:0] light,
    output logic       valid,
    output logic [1:0] phase
);

    always_comb begin
        valid = 1'b1;
        phase = PH_NONE;
        case (light)
            LIGHT_RED:    phase = PH_RED;
            LIGHT_GREEN:  phase = PH_GREEN;
            LIGHT_YELLOW: phase = PH_YELLOW;
            default:      valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor
// Description : Checks light encoding, R->G->Y->R order and per-phase dwell;
//               reports error pulses, a sticky flag and a cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned DWELL = DEFAULT_DWELL,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic             err_encoding,
    output logic             err_sequence,
    output logic             err_dwell,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned       DW_W      = $clog2(DWELL + 1);
    localparam logic [DW_W-1:0]   DWELL_MAX = DW_W'(DWELL);
    localparam logic [DW_W-1:0]   DWELL_ONE = DW_W'(1);

    logic       dec_valid;
    logic [1:0] dec_phase;

    traffic_light_decoder u_decoder (
        .light (light),
        .valid (dec_valid),
        .phase (dec_phase)
    );

    mon_state_e       state_q, state_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             overrun_q, overrun_d;
    logic             first_q, first_d;
    logic [1:0]       phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic             err_encoding_q, err_encoding_d;
    logic             err_sequence_q, err_sequence_d;
    logic             err_dwell_q, err_dwell_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    logic [1:0] cur_phase;
    logic       succ_legal;

    assign cur_phase = state_to_phase(state_q);

    always_comb begin
        succ_legal = 1'b0;
        case (cur_phase)
            PH_RED:    succ_legal = (dec_phase == PH_GREEN);
            PH_GREEN:  succ_legal = (dec_phase == PH_YELLOW);
            PH_YELLOW: succ_legal = (dec_phase == PH_RED);
            default:   succ_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        dwell_d        = dwell_q;
        overrun_d      = overrun_q;
        first_d        = first_q;
        phase_d        = dec_phase;
        phase_valid_d  = dec_valid;
        err_encoding_d = 1'b0;
        err_sequence_d = 1'b0;
        err_dwell_d    = 1'b0;
        cycle_count_d  = cycle_count_q;

        if (!dec_valid) begin
            err_encoding_d = 1'b1;
            phase_d        = PH_NONE;
            state_d        = ST_IDLE;
            dwell_d        = '0;
            overrun_d      = 1'b0;
            first_d        = 1'b0;
        end else if (state_q == ST_IDLE) begin
            // Entry phase is partial: it is never dwell-checked at its end.
            state_d   = phase_to_state(dec_phase);
            dwell_d   = DWELL_ONE;
            overrun_d = 1'b0;
            first_d   = 1'b1;
        end else if (dec_phase == cur_phase) begin
            if (dwell_q == DWELL_MAX) begin
                if (!overrun_q) begin
                    err_dwell_d = 1'b1;
                    overrun_d   = 1'b1;
                end
            end else begin
                dwell_d = dwell_q + DWELL_ONE;
            end
        end else begin
            err_sequence_d = !succ_legal;
            err_dwell_d    = !first_q && !overrun_q && (dwell_q != DWELL_MAX);
            if (succ_legal && (dec_phase == PH_RED)) begin
                cycle_count_d = cycle_count_q + 1'b1;
            end
            state_d   = phase_to_state(dec_phase);
            dwell_d   = DWELL_ONE;
            overrun_d = 1'b0;
            first_d   = 1'b0;
        end

        // A new error on this edge wins over a simultaneous clear.
        err_sticky_d = (err_sticky_q & ~clr_err) |
                       err_encoding_d | err_sequence_d | err_dwell_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            dwell_q        <= '0;
            overrun_q      <= 1'b0;
            first_q        <= 1'b0;
            phase_q        <= PH_NONE;
            phase_valid_q  <= 1'b0;
            err_encoding_q <= 1'b0;
            err_sequence_q <= 1'b0;
            err_dwell_q    <= 1'b0;
            err_sticky_q   <= 1'b0;
            cycle_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            dwell_q        <= dwell_d;
            overrun_q      <= overrun_d;
            first_q        <= first_d;
            phase_q        <= phase_d;
            phase_valid_q  <= phase_valid_d;
            err_encoding_q <= err_encoding_d;
            err_sequence_q <= err_sequence_d;
            err_dwell_q    <= err_dwell_d;
            err_sticky_q   <= err_sticky_d;
            cycle_count_q  <= cycle_count_d;
        end
    end

    assign phase        = phase_q;
    assign phase_valid  = phase_valid_q;
    assign err_encoding = err_encoding_q;
    assign err_sequence = err_sequence_q;
    assign err_dwell    = err_dwell_q;
    assign err_sticky   = err_sticky_q;
    assign cycle_count  = cycle_count_q;

endmodule
`default_nettype wire
